nn_zoffset_ctrl: RTL and testbench
==================================

# nn_zoffset_ctrl

Sequencer for the z-offset stage that feeds the burst gate. Per request it accepts an offset magnitude and a bitstream length. It clears the stochastic add/sub datapath, then generates the offset bitstream `d` from an internal LFSR for that many cycles. It counts the ones on the returned `zd` stream and hands the count back with a valid/ready handshake. One instance serves one z-offset datapath.

## Interface
- `WIDTH`, 8, offset magnitude width; also the number of LFSR bits compared.
- `LEN_W`, 10, bitstream length and result count width.
- `ZLAT`, 1, datapath latency in cycles from `d` to the corresponding `zd`.
- `SEED`, 16'd13441, LFSR reload value; must be nonzero.
- `CLK`  in  1  single clock, rising edge.
- `INIT`  in  1  reset, asynchronous, active-low.
- `abort`  in  1  synchronous cancel of the current request.
- `cfg_valid`  in  1  request valid.
- `cfg_ready`  out  1  request accepted when high together with `cfg_valid`.
- `cfg_offset`  in  WIDTH  offset magnitude; `d` probability is cfg_offset/2^WIDTH.
- `cfg_len`  in  LEN_W  bitstream length in cycles.
- `dp_init`  out  1  one-cycle active-high clear to the datapath.
- `d`  out  1  offset bitstream to the datapath.
- `zd`  in  1  datapath output bitstream.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumed when high together with `res_valid`.
- `res_count`  out  LEN_W  number of `zd` ones counted in the window.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, CLEAR, RUN and DONE.
- **IDLE:**
  - `cfg_ready`=1.
  - On `cfg_valid`&`cfg_ready`, capture `cfg_offset` and `cfg_len`, then go to CLEAR.
- **CLEAR** (1 cycle):
  - `dp_init`=1.
  - LFSR reloads `SEED`; the cycle counter and `res_count` clear to 0.
  - Go to RUN if len≠0, otherwise go to DONE.
- **RUN** (len+ZLAT cycles):
  - Cycles 0..len-1: `d` = (LFSR[WIDTH-1:0] < offset), and the LFSR advances one step per cycle.
  - Cycles len..len+ZLAT-1: `d`=0.
  - Cycles ZLAT..len+ZLAT-1: `res_count` increments when `zd`=1. The count cannot overflow, since it is at most len ≤ 2^LEN_W-1.
  - After the last cycle, go to DONE.
- **DONE:**
  - `res_valid`=1; `res_count` holds stable.
  - On `res_ready`, go to IDLE.
  - A new request is never accepted in DONE.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
- **abort:** from any non-IDLE state, go to IDLE next cycle.
  - `d`, `dp_init` and `res_valid` fall to 0 in that same next cycle.
  - No result is produced.
  - `abort` has no effect in IDLE.
- **offset=0:** `d` is never 1.
- **offset=2^WIDTH-1:** `d`=0 only when the compared LFSR bits are all ones.
- **Reset:** asynchronous, active-low `INIT`.
  - Forces IDLE and LFSR=SEED.
  - `dp_init`=0, `d`=0, `res_valid`=0, `res_count`=0, `busy`=0.
  - `cfg_ready`=1, but no transfer is accepted while `INIT` is low.
  - Reset in mid-request discards the request.

## Timing
- All outputs are registered except `cfg_ready` and `busy`, which decode directly from the state.
- With the request accepted at edge k:
  - `dp_init` is high in cycle k+1.
  - `d` is valid in cycles k+2..k+1+len.
  - `zd` is sampled in cycles k+2+ZLAT..k+1+len+ZLAT.
  - `res_valid` rises in cycle k+2+len+ZLAT.
- len=0: `res_valid` rises in cycle k+2 with `res_count`=0.
- `res_ready` sampled high at edge m: IDLE in cycle m+1, and the earliest next accept is edge m+1.
- Back-to-back throughput is one request per len+ZLAT+3 cycles.
- `abort` and `res_ready` both high in DONE: abort wins, with the identical result of going to IDLE.

## Structure
- A shared package holds:
  - the state encoding (IDLE=0, CLEAR=1, RUN=2, DONE=3);
  - the default `SEED` and the LFSR tap constants.
- One sub-module, `nn_lfsr16`: ports `CLK`, `INIT`, `load`, `en`, `seed[15:0]`, `q[15:0]`. It is reusable by the other stochastic-number generators.
- FSM, counters and comparator stay in `nn_zoffset_ctrl`.

## Test plan
- **offset=0, len=16, `zd` tied 1:**
  - `d` is 0 throughout.
  - `res_count`=16 and `res_valid` at k+19 (ZLAT=1).
- **offset=128, len=256, `zd`=`d` delayed 1 cycle:**
  - `res_count` equals the model count of LFSR[7:0]<128 over 256 steps from 13441.
  - Bit-exact `d` sequence versus the model.
- **len=0:**
  - `dp_init` pulses in k+1, no `d` activity.
  - `res_valid` at k+2 with count 0.
- **Result backpressure:** `res_ready` held low 5 cycles in DONE.
  - `res_valid` and `res_count` stay stable, and `cfg_valid` is not accepted.
  - Handshake, then `cfg_ready`=1 the next cycle.
- **abort in RUN cycle 5 of len=32:**
  - IDLE next cycle, `d`=0, no `res_valid`.
  - The next request starts with the LFSR reloaded to SEED.
- **`INIT` low mid-RUN:**
  - Outputs immediately at reset values, without waiting for a clock edge.
  - After release, a fresh request produces a correct count.

Source files
------------

// File: rtl/nn_zoffset_ctrl_pkg.sv
// Shared constants for the z-offset sequencer: FSM encoding, LFSR seed/taps
// and the LFSR next-state function reused by other stochastic generators.
package nn_zoffset_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [15:0] LFSR_SEED_DEF = 16'd13441;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/nn_lfsr16.sv
// 16-bit Fibonacci LFSR (shift left, feedback into bit 0) with synchronous
// seed load; reset returns it to RST_VAL.
module nn_lfsr16
   import nn_zoffset_ctrl_pkg::*;
#(
   parameter logic [15:0] RST_VAL = LFSR_SEED_DEF
) (
   input  logic        CLK,
   input  logic        INIT,
   input  logic        load,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   // LFSR state: load has priority over stepping
   always_ff @(posedge CLK or negedge INIT) begin
      if (!INIT) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= seed;
      end else if (en) begin
         q <= lfsr16_next(q);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/nn_zoffset_ctrl.sv
// Z-offset sequencer: clears the add/sub datapath, drives an LFSR-derived
// offset bitstream for len cycles and counts ones on the returned stream.
module nn_zoffset_ctrl
   import nn_zoffset_ctrl_pkg::*;
#(
   parameter int          WIDTH = 8,
   parameter int          LEN_W = 10,
   parameter int          ZLAT  = 1,
   parameter logic [15:0] SEED  = LFSR_SEED_DEF
) (
   input  logic             CLK,
   input  logic             INIT,
   input  logic             abort,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_offset,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             dp_init,
   output logic             d,
   input  logic             zd,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [LEN_W-1:0] res_count,
   output logic             busy
);

   localparam logic [LEN_W:0]   CYC_ONE = (LEN_W+1)'(1);
   localparam logic [LEN_W:0]   ZLAT_E  = (LEN_W+1)'(ZLAT);
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   logic [1:0]       state_r;
   logic [WIDTH-1:0] offset_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W:0]   cyc_r;
   logic [LEN_W-1:0] res_count_r;
   logic             dp_init_r;
   logic             d_r;
   logic             res_valid_r;

   logic [15:0]      lfsr_q_s;
   logic             lfsr_hi_unused_s;
   logic             lfsr_en_s;
   logic             accept_s;
   logic             cmp_s;
   logic             more_d_s;
   logic             sample_s;
   logic             run_last_s;
   logic [LEN_W:0]   len_ext_s;

   assign cfg_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign dp_init   = dp_init_r;
   assign d         = d_r;
   assign res_valid = res_valid_r;
   assign res_count = res_count_r;

   assign accept_s   = cfg_valid & (state_r == ST_IDLE);
   assign len_ext_s  = {1'b0, len_r};
   assign cmp_s      = (lfsr_q_s[WIDTH-1:0] < offset_r);
   // cyc_r is the RUN cycle index; more_d_s means the next cycle still carries d
   assign more_d_s   = ((cyc_r + CYC_ONE) < len_ext_s);
   assign sample_s   = (cyc_r >= ZLAT_E);
   assign run_last_s = (cyc_r == (len_ext_s + ZLAT_E - CYC_ONE));
   assign lfsr_hi_unused_s = ^lfsr_q_s;

   // The LFSR is seeded at accept so it holds SEED throughout CLEAR
   nn_lfsr16 #(
      .RST_VAL (SEED)
   ) u_lfsr (
      .CLK  (CLK),
      .INIT (INIT),
      .load (accept_s),
      .en   (lfsr_en_s),
      .seed (SEED),
      .q    (lfsr_q_s)
   );

   // LFSR stepping: one step per emitted d bit
   always_comb begin
      lfsr_en_s = 1'b0;
      case (state_r)
         ST_CLEAR: lfsr_en_s = (len_r != {LEN_W{1'b0}});
         ST_RUN:   lfsr_en_s = more_d_s;
         default:  lfsr_en_s = 1'b0;
      endcase
   end

   // Sequencer FSM, window counter, result counter and registered outputs
   always_ff @(posedge CLK or negedge INIT) begin
      if (!INIT) begin
         state_r     <= ST_IDLE;
         offset_r    <= {WIDTH{1'b0}};
         len_r       <= {LEN_W{1'b0}};
         cyc_r       <= {(LEN_W+1){1'b0}};
         res_count_r <= {LEN_W{1'b0}};
         dp_init_r   <= 1'b0;
         d_r         <= 1'b0;
         res_valid_r <= 1'b0;
      end else if (abort && (state_r != ST_IDLE)) begin
         state_r     <= ST_IDLE;
         dp_init_r   <= 1'b0;
         d_r         <= 1'b0;
         res_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cfg_valid) begin
                  offset_r  <= cfg_offset;
                  len_r     <= cfg_len;
                  dp_init_r <= 1'b1;
                  state_r   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               dp_init_r   <= 1'b0;
               cyc_r       <= {(LEN_W+1){1'b0}};
               res_count_r <= {LEN_W{1'b0}};
               if (len_r != {LEN_W{1'b0}}) begin
                  state_r <= ST_RUN;
                  d_r     <= cmp_s;
               end else begin
                  state_r     <= ST_DONE;
                  res_valid_r <= 1'b1;
               end
            end
            ST_RUN: begin
               cyc_r <= cyc_r + CYC_ONE;
               d_r   <= more_d_s & cmp_s;
               if (sample_s && zd) begin
                  res_count_r <= res_count_r + CNT_ONE;
               end
               if (run_last_s) begin
                  state_r     <= ST_DONE;
                  res_valid_r <= 1'b1;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state_r     <= ST_IDLE;
                  res_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               dp_init_r   <= 1'b0;
               d_r         <= 1'b0;
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_zoffset_ctrl.sv
// Directed bench for nn_zoffset_ctrl: reference LFSR model, exact cycle
// timing of dp_init/d/res_valid, backpressure, abort and async reset.
module tb_nn_zoffset_ctrl;

   localparam int WIDTH = 8;
   localparam int LEN_W = 10;
   localparam int ZLAT  = 1;

   logic             CLK        = 1'b0;
   logic             INIT       = 1'b0;
   logic             abort      = 1'b0;
   logic             cfg_valid  = 1'b0;
   logic [WIDTH-1:0] cfg_offset = '0;
   logic [LEN_W-1:0] cfg_len    = '0;
   logic             res_ready  = 1'b0;
   logic             zd_sel     = 1'b0;
   logic             zd_tie     = 1'b0;
   logic             zd_dly     = 1'b0;
   logic             zd;
   logic             cfg_ready, dp_init, d, res_valid, busy;
   logic [LEN_W-1:0] res_count;
   logic [LEN_W-1:0] ones;

   int errors = 0;
   int checks = 0;

   assign zd = zd_sel ? zd_dly : zd_tie;

   always #5 CLK = ~CLK;

   // zd = d delayed by one cycle (ZLAT=1 datapath stand-in)
   always @(posedge CLK) zd_dly <= d;

   nn_zoffset_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ZLAT(ZLAT), .SEED(16'd13441)) dut (
      .CLK        (CLK),
      .INIT       (INIT),
      .abort      (abort),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_offset (cfg_offset),
      .cfg_len    (cfg_len),
      .dp_init    (dp_init),
      .d          (d),
      .zd         (zd),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_count  (res_count),
      .busy       (busy)
   );

   function automatic logic [15:0] model_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a request; returns at the negedge of cycle k+1
   task automatic start(input logic [WIDTH-1:0] off, input logic [LEN_W-1:0] len);
      @(negedge CLK);
      cfg_offset = off;
      cfg_len    = len;
      cfg_valid  = 1'b1;
      chk("cfg_ready_idle", cfg_ready, 1);
      @(negedge CLK);
      cfg_valid = 1'b0;
      chk("dp_init_k1", dp_init, 1);
      chk("busy_k1", busy, 1);
      chk("d_k1", d, 0);
   endtask

   // Walk the d window and latency tail against the model; ends at res_valid rise
   task automatic run_body(input logic [WIDTH-1:0] off, input logic [LEN_W-1:0] len,
                           output logic [LEN_W-1:0] n_ones);
      logic [15:0] lf;
      logic        md;
      int          bad;
      int          rv;
      lf = 16'd13441;
      bad = 0;
      rv = 0;
      n_ones = '0;
      for (int j = 0; j < int'(len); j++) begin
         @(negedge CLK);
         md = (lf[WIDTH-1:0] < off);
         lf = model_step(lf);
         if (d !== md) bad++;
         if (res_valid !== 1'b0) rv++;
         n_ones = n_ones + LEN_W'(md);
      end
      if (len != 0) begin
         for (int t = 0; t < ZLAT; t++) begin
            @(negedge CLK);
            if (d !== 1'b0) bad++;
            if (res_valid !== 1'b0) rv++;
         end
      end
      chk("d_seq_mismatches", bad, 0);
      chk("res_valid_early", rv, 0);
      @(negedge CLK);
      chk("res_valid_rise", res_valid, 1);
      chk("d_in_done", d, 0);
   endtask

   // Hold off the result for 'hold' cycles, then complete the handshake
   task automatic release_res(input int hold, input logic [LEN_W-1:0] expcnt);
      chk("res_count", res_count, expcnt);
      for (int i = 0; i < hold; i++) begin
         cfg_valid = 1'b1;
         @(negedge CLK);
         chk("hold_valid", res_valid, 1);
         chk("hold_count", res_count, expcnt);
         chk("hold_no_accept", cfg_ready, 0);
      end
      cfg_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      chk("post_hs_valid", res_valid, 0);
      chk("post_hs_ready", cfg_ready, 1);
      chk("post_hs_busy", busy, 0);
   endtask

   initial begin
      // Reset state, and no accept while INIT is low
      #1;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_dp_init", dp_init, 0);
      chk("rst_d", d, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_count", res_count, 0);
      cfg_valid = 1'b1;
      cfg_len   = 10'd4;
      @(negedge CLK);
      chk("rst_no_accept", busy, 0);
      cfg_valid = 1'b0;
      INIT = 1'b1;

      // offset=0, len=16, zd tied high: d never 1, count 16 at k+19
      zd_sel = 1'b0;
      zd_tie = 1'b1;
      start(8'd0, 10'd16);
      run_body(8'd0, 10'd16, ones);
      release_res(0, 10'd16);

      // offset=128, len=256, zd = d delayed
      zd_sel = 1'b1;
      start(8'd128, 10'd256);
      run_body(8'd128, 10'd256, ones);
      release_res(0, ones);

      // len=0 with 5 cycles of result backpressure
      start(8'd77, 10'd0);
      run_body(8'd77, 10'd0, ones);
      release_res(5, 10'd0);

      // abort in RUN cycle 5 of a len=32 request
      start(8'd90, 10'd32);
      repeat (6) @(negedge CLK);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", cfg_ready, 1);
      chk("abort_d", d, 0);
      chk("abort_valid", res_valid, 0);
      repeat (3) @(negedge CLK);
      chk("abort_no_result", res_valid, 0);
      start(8'd200, 10'd8);
      run_body(8'd200, 10'd8, ones);
      release_res(0, ones);

      // INIT asserted mid-RUN: outputs drop without a clock edge
      zd_sel = 1'b0;
      zd_tie = 1'b1;
      start(8'd100, 10'd40);
      repeat (10) @(negedge CLK);
      #2;
      INIT = 1'b0;
      #1;
      chk("init_busy", busy, 0);
      chk("init_ready", cfg_ready, 1);
      chk("init_d", d, 0);
      chk("init_dp_init", dp_init, 0);
      chk("init_valid", res_valid, 0);
      chk("init_count", res_count, 0);
      cfg_valid = 1'b1;
      @(negedge CLK);
      chk("init_no_accept", busy, 0);
      cfg_valid = 1'b0;
      INIT = 1'b1;

      // Fresh request after reset, full-scale offset
      zd_sel = 1'b1;
      start(8'd255, 10'd64);
      run_body(8'd255, 10'd64, ones);
      release_res(0, ones);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
